clock_controller: RTL and testbench
===================================

CLOCK_CONTROLLER -- requirements
Module: clock_controller

Interface
REQ-001 Parameter DEFAULT_FACTOR, default 32'd500, divide factor loaded at reset.
REQ-002 Parameter TICK_W, default 16, width of tick_count.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 cfg_valid  input  1  new divide factor offered on cfg_factor.
REQ-006 cfg_factor  input  32  requested divide factor, in clk_in cycles per output period.
REQ-007 cfg_ready  output  1  high when the block can accept a new factor.
REQ-008 run  input  1  request continuous running; level sampled each cycle.
REQ-009 halt  input  1  request stop at the end of the current period; level sampled each cycle.
REQ-010 step  input  1  request exactly one divided period while halted; level sampled each cycle.
REQ-011 clk_out  output  1  divided square wave, registered.
REQ-012 clk_en  output  1  one-cycle pulse marking the last clk_in cycle of each completed period, registered.
REQ-013 state  output  2  current state: 00 HALTED, 01 RUN, 10 STEP.
REQ-014 tick_count  output  TICK_W  number of clk_en pulses issued since reset, modulo 2^TICK_W.

Function
REQ-015 Internal 32-bit counter cnt and active factor F; period length is F cycles, cnt runs 0..F-1.
REQ-016 In RUN or STEP: cnt increments each cycle; on cnt==F-1, cnt wraps to 0 (the wrap cycle).
REQ-017 In RUN or STEP: clk_out is registered high when cnt < F/2 (integer division), otherwise low.
REQ-018 clk_en is registered high in the cycle after the wrap cycle, for exactly one cycle.
REQ-019 In HALTED: cnt held at 0, clk_out held low, clk_en low.
REQ-020 HALTED -> RUN when run=1, halt=0, step=0; counting starts at cnt=0 on the next cycle.
REQ-021 HALTED -> STEP when step=1 and halt=0; priority for simultaneous requests: halt > step > run.
REQ-022 STEP -> HALTED on its wrap cycle; exactly one clk_en pulse is issued per STEP entry.
REQ-023 A step held high across the return to HALTED causes one further STEP entry per HALTED cycle in which step is sampled high.
REQ-024 In RUN, halt=1 sets a sticky halt_pend flag; at the next wrap cycle the state becomes HALTED and halt_pend clears.
REQ-025 The final period of RUN always completes, so the block never truncates a period.
REQ-026 In RUN, run and step are ignored; in STEP, run, halt and step are ignored.
REQ-027 cfg_ready is high when no pending factor is held.
REQ-028 A factor is accepted on a cycle with cfg_valid && cfg_ready and is stored as pending; cfg_ready then goes low.
REQ-029 A pending factor is applied to F at the next wrap cycle, or on the next cycle if the state is HALTED; cfg_ready returns high in the cycle after it is applied.
REQ-030 cfg_factor values 0 and 1 are clamped to 2 on acceptance.
REQ-031 tick_count increments by 1 with each clk_en pulse and wraps from all-ones to 0.

Reset
REQ-032 While rst_n is low: state=HALTED, cnt=0, F=DEFAULT_FACTOR, no pending factor, halt_pend=0, clk_out=0, clk_en=0, tick_count=0, cfg_ready=1.
REQ-033 Asserting rst_n mid-period aborts the period immediately, with no clk_en pulse.
REQ-034 After rst_n deasserts, the block stays HALTED until a run or step request is sampled.

Verification
REQ-035 Reset, then run=1 with F=500 -> clk_out high 250 cycles, low 250 cycles; clk_en pulses every 500 cycles; tick_count=4 after 2000 cycles.
REQ-036 cfg_factor=10 accepted mid-period while in RUN -> current 500-cycle period completes; subsequent periods are 10 cycles (5 high, 5 low); cfg_ready is low until the factor is applied.
REQ-037 halt pulsed at cnt=100 in RUN -> clk_en pulses at period end, state=00 afterwards, clk_out stays low.
REQ-038 With F=4, step pulsed once from HALTED -> state=10 for 4 cycles, exactly one clk_en pulse, then state=00 and tick_count +1.
REQ-039 run, step and halt asserted together in HALTED -> state stays 00; step and run together -> state=10.
REQ-040 cfg_factor=0 accepted while HALTED, then run -> period of 2 cycles (1 high, 1 low); rst_n low mid-period -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/clock_controller.sv
// Programmable clock divider with run / halt / single-step control.
// Produces a registered divided square wave, a one-cycle enable pulse per
// completed period, and a count of those pulses. A new divide factor can be
// offered at any time; it is held as pending and applied only at a period
// boundary (or immediately while halted), so no period is ever truncated.
module clock_controller #(
  parameter logic [31:0] DEFAULT_FACTOR = 32'd500,
  parameter int unsigned TICK_W         = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [31:0]       cfg_factor,
  output logic              cfg_ready,
  input  logic              run,
  input  logic              halt,
  input  logic              step,
  output logic              clk_out,
  output logic              clk_en,
  output logic [1:0]        state,
  output logic [TICK_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    StHalted = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10
  } state_e;

  state_e              state_q;
  logic [31:0]         cnt_q;
  logic [31:0]         factor_q;
  logic [31:0]         pend_factor_q;
  logic                pend_valid_q;
  logic                halt_pend_q;
  logic                clk_out_q;
  logic                clk_en_q;
  logic [TICK_W-1:0]   tick_q;

  logic                counting;
  logic                wrap;
  logic                accept;
  logic [31:0]         cfg_clamped;
  logic                high_phase;

  // Period bookkeeping shared by the state register below.
  always_comb begin
    counting    = (state_q != StHalted);
    wrap        = counting && (cnt_q == (factor_q - 32'd1));
    accept      = cfg_valid && !pend_valid_q;
    // Factors below 2 cannot form a high and a low phase.
    cfg_clamped = (cfg_factor < 32'd2) ? 32'd2 : cfg_factor;
    high_phase  = (cnt_q < (factor_q >> 1));
  end

  // Control FSM, period counter, factor staging and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHalted;
      cnt_q         <= 32'd0;
      factor_q      <= DEFAULT_FACTOR;
      pend_factor_q <= 32'd0;
      pend_valid_q  <= 1'b0;
      halt_pend_q   <= 1'b0;
      clk_out_q     <= 1'b0;
      clk_en_q      <= 1'b0;
      tick_q        <= '0;
    end else begin
      // Pulse lands in the cycle after the wrap cycle.
      clk_en_q <= wrap;
      if (wrap) begin
        tick_q <= tick_q + {{(TICK_W-1){1'b0}}, 1'b1};
      end

      // Pending factor takes effect only on a period boundary or while idle.
      if (pend_valid_q && (wrap || (state_q == StHalted))) begin
        factor_q     <= pend_factor_q;
        pend_valid_q <= 1'b0;
      end else if (accept) begin
        pend_factor_q <= cfg_clamped;
        pend_valid_q  <= 1'b1;
      end

      unique case (state_q)
        StHalted: begin
          cnt_q       <= 32'd0;
          clk_out_q   <= 1'b0;
          halt_pend_q <= 1'b0;
          // halt outranks step, step outranks run.
          if (!halt) begin
            if (step) begin
              state_q <= StStep;
            end else if (run) begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          clk_out_q <= high_phase;
          if (wrap) begin
            cnt_q       <= 32'd0;
            halt_pend_q <= 1'b0;
            if (halt_pend_q || halt) begin
              state_q <= StHalted;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (halt) begin
              halt_pend_q <= 1'b1;
            end
          end
        end
        StStep: begin
          clk_out_q <= high_phase;
          if (wrap) begin
            cnt_q   <= 32'd0;
            state_q <= StHalted;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q     <= StHalted;
          cnt_q       <= 32'd0;
          clk_out_q   <= 1'b0;
          halt_pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = !pend_valid_q;
  assign clk_out    = clk_out_q;
  assign clk_en     = clk_en_q;
  assign state      = state_q;
  assign tick_count = tick_q;

endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller. Inputs are driven and outputs sampled
// on the falling edge; k counts falling edges from the first run request.
module tb_clock_controller;

  localparam int unsigned TW = 4;

  logic          clk_in;
  logic          rst_n;
  logic          cfg_valid;
  logic [31:0]   cfg_factor;
  logic          cfg_ready;
  logic          run;
  logic          halt;
  logic          step;
  logic          clk_out;
  logic          clk_en;
  logic [1:0]    state;
  logic [TW-1:0] tick_count;

  int n_asserts;
  int n_fail;
  int k;
  int en_cnt;

  clock_controller #(
    .DEFAULT_FACTOR(32'd500),
    .TICK_W        (TW)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_factor(cfg_factor),
    .cfg_ready (cfg_ready),
    .run       (run),
    .halt      (halt),
    .step      (step),
    .clk_out   (clk_out),
    .clk_en    (clk_en),
    .state     (state),
    .tick_count(tick_count)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to falling edge number t, counting enable pulses on the way.
  task automatic adv_to(input int t);
    while (k < t) begin
      @(negedge clk_in);
      k++;
      if (clk_en === 1'b1) en_cnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    check({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    check({tag, "_tick"}, 32'(tick_count), 32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    n_asserts  = 0;
    n_fail     = 0;
    k          = 0;
    en_cnt     = 0;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_factor = 32'd0;
    run        = 1'b0;
    halt       = 1'b0;
    step       = 1'b0;

    // Reset state, then stay halted with no request.
    repeat (3) @(negedge clk_in);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    check("idle_after_reset", 32'(state), 32'd0);
    check("idle_clk_out", 32'(clk_out), 32'd0);

    // Run with default factor 500.
    k = 0; en_cnt = 0;
    run = 1'b1;
    adv_to(1);    check("run_state", 32'(state), 32'd1);
                  check("run_first_low", 32'(clk_out), 32'd0);
    run = 1'b0;
    adv_to(2);    check("run_high_start", 32'(clk_out), 32'd1);
    adv_to(251);  check("run_high_end", 32'(clk_out), 32'd1);
    adv_to(252);  check("run_low_start", 32'(clk_out), 32'd0);
    adv_to(500);  check("run_no_early_en", 32'(clk_en), 32'd0);
    adv_to(501);  check("run_en_500", 32'(clk_en), 32'd1);
                  check("run_tick1", 32'(tick_count), 32'd1);
    adv_to(502);  check("run_en_one_cycle", 32'(clk_en), 32'd0);
                  check("run_high_again", 32'(clk_out), 32'd1);
    adv_to(2001); check("run_en_count", 32'(en_cnt), 32'd4);
                  check("run_tick4", 32'(tick_count), 32'd4);

    // New factor 10 mid-period: current period finishes first.
    adv_to(2101); cfg_factor = 32'd10; cfg_valid = 1'b1;
    adv_to(2102); check("cfg_ready_low", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    adv_to(2500); check("cfg_still_pending", 32'(cfg_ready), 32'd0);
                  check("cfg_no_trunc", 32'(clk_en), 32'd0);
    adv_to(2501); check("cfg_old_period_en", 32'(clk_en), 32'd1);
                  check("cfg_ready_back", 32'(cfg_ready), 32'd1);
                  check("cfg_tick5", 32'(tick_count), 32'd5);
    adv_to(2502); check("f10_high_start", 32'(clk_out), 32'd1);
    adv_to(2506); check("f10_high_end", 32'(clk_out), 32'd1);
    adv_to(2507); check("f10_low_start", 32'(clk_out), 32'd0);
    adv_to(2510); check("f10_no_early_en", 32'(clk_en), 32'd0);
    adv_to(2511); check("f10_en", 32'(clk_en), 32'd1);
                  check("f10_tick6", 32'(tick_count), 32'd6);

    // Halt pulse mid-period: period completes, then halted.
    adv_to(2514); halt = 1'b1;
    adv_to(2515); halt = 1'b0;
                  check("halt_still_run", 32'(state), 32'd1);
    adv_to(2520); check("halt_pending_run", 32'(state), 32'd1);
    adv_to(2521); check("halt_state", 32'(state), 32'd0);
                  check("halt_final_en", 32'(clk_en), 32'd1);
                  check("halt_tick7", 32'(tick_count), 32'd7);
    adv_to(2525); check("halt_clk_out_low", 32'(clk_out), 32'd0);
                  check("halt_stays", 32'(state), 32'd0);

    // Factor 4 while halted applies on the next cycle.
    adv_to(2530); cfg_factor = 32'd4; cfg_valid = 1'b1;
    adv_to(2531); check("f4_pending", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    adv_to(2532); check("f4_applied", 32'(cfg_ready), 32'd1);
    en_cnt = 0;

    // Single step of 4 cycles.
    adv_to(2535); step = 1'b1;
    adv_to(2536); step = 1'b0;
                  check("step_state", 32'(state), 32'd2);
    adv_to(2537); check("step_high", 32'(clk_out), 32'd1);
    adv_to(2539); check("step_state_last", 32'(state), 32'd2);
                  check("step_low", 32'(clk_out), 32'd0);
    adv_to(2540); check("step_done", 32'(state), 32'd0);
                  check("step_en", 32'(clk_en), 32'd1);
                  check("step_tick8", 32'(tick_count), 32'd8);
    adv_to(2545); check("step_one_pulse", 32'(en_cnt), 32'd1);

    // Step held high: re-enters STEP after each halted cycle.
    step = 1'b1;
    adv_to(2550); check("hold_back_halted", 32'(state), 32'd0);
                  check("hold_tick9", 32'(tick_count), 32'd9);
    adv_to(2551); check("hold_reenter", 32'(state), 32'd2);
    adv_to(2555); check("hold_halted2", 32'(state), 32'd0);
                  check("hold_tick10", 32'(tick_count), 32'd10);
    step = 1'b0;
    adv_to(2556); check("hold_released", 32'(state), 32'd0);

    // Simultaneous requests: halt wins, then step beats run.
    adv_to(2560); run = 1'b1; step = 1'b1; halt = 1'b1;
    adv_to(2561); check("prio_halt", 32'(state), 32'd0);
    halt = 1'b0;
    adv_to(2562); check("prio_step", 32'(state), 32'd2);
    run = 1'b0; step = 1'b0;
    adv_to(2566); check("prio_step_done", 32'(state), 32'd0);
                  check("prio_tick11", 32'(tick_count), 32'd11);

    // Factor 0 clamps to 2.
    adv_to(2570); cfg_factor = 32'd0; cfg_valid = 1'b1;
    adv_to(2571); check("f0_pending", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    adv_to(2572); check("f0_applied", 32'(cfg_ready), 32'd1);
    adv_to(2575); run = 1'b1;
    adv_to(2576); run = 1'b0;
                  check("f2_state", 32'(state), 32'd1);
    adv_to(2577); check("f2_high", 32'(clk_out), 32'd1);
    adv_to(2578); check("f2_low", 32'(clk_out), 32'd0);
                  check("f2_en", 32'(clk_en), 32'd1);
                  check("f2_tick12", 32'(tick_count), 32'd12);
    adv_to(2579); check("f2_high2", 32'(clk_out), 32'd1);
                  check("f2_en_gap", 32'(clk_en), 32'd0);
    adv_to(2584); check("tick_all_ones", 32'(tick_count), 32'd15);
    adv_to(2586); check("tick_wrap", 32'(tick_count), 32'd0);
    adv_to(2587); cfg_factor = 32'd7; cfg_valid = 1'b1;
    adv_to(2588); cfg_valid = 1'b0;
                  check("pre_rst_en", 32'(clk_en), 32'd1);
                  check("pre_rst_tick", 32'(tick_count), 32'd1);
                  check("pre_rst_pending", 32'(cfg_ready), 32'd0);

    // Asynchronous reset mid-run takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    adv_to(2592); rst_n = 1'b1;
    adv_to(2593); check("post_rst_halted", 32'(state), 32'd0);

    // Default factor restored; the pre-reset pending 7 was discarded.
    adv_to(2595); run = 1'b1;
    adv_to(2596); run = 1'b0;
                  check("rerun_state", 32'(state), 32'd1);
    adv_to(2846); check("rerun_high_end", 32'(clk_out), 32'd1);
    adv_to(2847); check("rerun_low_start", 32'(clk_out), 32'd0);
    adv_to(3095); check("rerun_no_early_en", 32'(clk_en), 32'd0);
    adv_to(3096); check("rerun_en", 32'(clk_en), 32'd1);
                  check("rerun_tick1", 32'(tick_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
